disp_page_sel: RTL and testbench

- Upstream source for the 4-digit hex display: selects which 16-bit slice of CPU state drives the display's 16-bit data input.
- Four pages: result low/high halves and PC low/high halves. A raw push-button advances the page; a freeze switch holds a snapshot.
- Synchronizes and debounces the raw button internally. Runs on the board clock, ahead of the display's own clock divider.

---
 rtl/disp_page_sel_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/disp_page_sel.sv | 76 +++++++
 tb/tb_disp_page_sel.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/disp_page_sel_pkg.sv
// Shared definitions for the hex-display page selector: page encodings and the slice mux.
// The page constants are also intended for status LEDs that report the current page.
package disp_page_sel_pkg;

  typedef logic [1:0] page_t;

  localparam page_t PAGE_RES_LO = 2'd0;
  localparam page_t PAGE_RES_HI = 2'd1;
  localparam page_t PAGE_PC_LO  = 2'd2;
  localparam page_t PAGE_PC_HI  = 2'd3;

  // Selects the 16-bit slice of CPU state shown for a given page.
  function automatic logic [15:0] page_slice(input page_t       pg,
                                             input logic [31:0] res,
                                             input logic [31:0] pc);
    logic [15:0] slice;
    slice = res[15:0];
    unique case (pg)
      PAGE_RES_LO: slice = res[15:0];
      PAGE_RES_HI: slice = res[31:16];
      PAGE_PC_LO:  slice = pc[15:0];
      PAGE_PC_HI:  slice = pc[31:16];
      default:     slice = res[15:0];
    endcase
    return slice;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus disagreement counter for a raw mechanical push-button.
// clean_nxt is the value clean takes at the next edge, so callers can act on that same edge.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic in_clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic clean_nxt
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign btn_s = sync_q[1];

  // Any sample agreeing with the debounced level restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (btn_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      db_d  = btn_s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign clean     = db_q;
  assign clean_nxt = db_d;

endmodule

// File: rtl/disp_page_sel.sv
// Chooses which 16-bit slice of CPU result/PC feeds the hex display; a debounced button
// steps through the pages and a freeze switch holds a snapshot of both buses.
module disp_page_sel
  import disp_page_sel_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic [31:0] result,
  input  logic [31:0] pc,
  input  logic        btn_next,
  input  logic        freeze,
  output logic [15:0] data,
  output logic [1:0]  page,
  output logic        page_pulse
);

  logic        btn_db, btn_db_nxt, press;
  page_t       page_q, page_d;
  logic        pulse_q, pulse_d;
  logic [31:0] snap_res_q, snap_res_d;
  logic [31:0] snap_pc_q, snap_pc_d;
  logic [15:0] data_q, data_d;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_btn_debounce (
    .in_clk   (in_clk),
    .reset    (reset),
    .raw      (btn_next),
    .clean    (btn_db),
    .clean_nxt(btn_db_nxt)
  );

  // Advance on the same edge the debounced level rises; releases are ignored.
  assign press = btn_db_nxt & ~btn_db;

  always_comb begin
    page_d     = page_q;
    pulse_d    = press;
    snap_res_d = snap_res_q;
    snap_pc_d  = snap_pc_q;
    if (press) begin
      page_d = page_q + 2'd1;
    end
    if (!freeze) begin
      snap_res_d = result;
      snap_pc_d  = pc;
    end
    data_d = page_slice(page_q, snap_res_q, snap_pc_q);
  end

  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      page_q     <= PAGE_RES_LO;
      pulse_q    <= 1'b0;
      snap_res_q <= '0;
      snap_pc_q  <= '0;
      data_q     <= 16'h0000;
    end else begin
      page_q     <= page_d;
      pulse_q    <= pulse_d;
      snap_res_q <= snap_res_d;
      snap_pc_q  <= snap_pc_d;
      data_q     <= data_d;
    end
  end

  assign data       = data_q;
  assign page       = page_q;
  assign page_pulse = pulse_q;

endmodule

// File: tb/tb_disp_page_sel.sv
// Scoreboard bench for disp_page_sel: each press pushes the expected page, data and pulse
// cycle; a monitor checks every page_pulse the DUT raises against the queue.
module tb_disp_page_sel;

  localparam int unsigned DB = 8;

  typedef struct {
    logic [1:0]  page;
    logic [15:0] data;
    int          at_cyc;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] result = 32'hDEADBEEF;
  logic [31:0] pc     = 32'h00400010;
  logic        btn_next = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] data;
  logic [1:0]  page;
  logic        page_pulse;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  disp_page_sel #(
    .DB_CYCLES(DB),
    .CNT_W    (4)
  ) dut (
    .in_clk    (in_clk),
    .reset     (reset),
    .result    (result),
    .pc        (pc),
    .btn_next  (btn_next),
    .freeze    (freeze),
    .data      (data),
    .page      (page),
    .page_pulse(page_pulse)
  );

  always #5 in_clk = ~in_clk;

  always @(posedge in_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Press cleanly, hold well past the debounce window, then release and let it settle.
  task automatic press(input logic [1:0] p, input logic [15:0] d);
    exp_t e;
    @(negedge in_clk);
    btn_next = 1'b1;
    e.page   = p;
    e.data   = d;
    e.at_cyc = cyc + 1 + DB + 1;
    sb.push_back(e);
    repeat (14) @(negedge in_clk);
    btn_next = 1'b0;
    repeat (14) @(negedge in_clk);
  endtask

  // Monitor: every pulse must match the oldest expectation, last one cycle, and update data.
  always @(negedge in_clk) begin
    if (!reset && page_pulse) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'd0, page_pulse}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_page", {30'd0, page}, {30'd0, e.page});
        check("pulse_cycle", cyc, e.at_cyc);
        @(negedge in_clk);
        check("pulse_width", {31'd0, page_pulse}, 32'd0);
        check("page_data", {16'd0, data}, {16'd0, e.data});
      end
    end
  end

  initial begin
    int c;
    repeat (3) @(negedge in_clk);
    check("rst_page", {30'd0, page}, 32'd0);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_pulse", {31'd0, page_pulse}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge in_clk);
    check("live_data_p0", {16'd0, data}, 32'h0000BEEF);

    // Walk through all pages and wrap.
    press(2'd1, 16'hDEAD);
    press(2'd2, 16'h0010);
    press(2'd3, 16'h0040);
    press(2'd0, 16'hBEEF);

    // Bounce: 3-sample runs never reach the debounce window.
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      repeat (3) @(negedge in_clk);
    end
    btn_next = 1'b0;
    repeat (20) @(negedge in_clk);
    check("bounce_page", {30'd0, page}, 32'd0);
    check("bounce_data", {16'd0, data}, 32'h0000BEEF);

    // Freeze holds the snapshot; page changes still select frozen slices.
    result = 32'h12345678;
    repeat (3) @(negedge in_clk);
    check("pre_freeze_data", {16'd0, data}, 32'h00005678);
    freeze = 1'b1;
    @(negedge in_clk);
    result = 32'hFFFFFFFF;
    repeat (4) @(negedge in_clk);
    check("frozen_data", {16'd0, data}, 32'h00005678);
    press(2'd1, 16'h1234);
    check("frozen_hi_data", {16'd0, data}, 32'h00001234);
    freeze = 1'b0;
    repeat (2) @(negedge in_clk);
    check("unfreeze_data", {16'd0, data}, 32'h0000FFFF);

    // Reset in the middle of a debounce with page=2 discards the count.
    press(2'd2, 16'h0010);
    btn_next = 1'b1;
    repeat (4) @(negedge in_clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_page", {30'd0, page}, 32'd0);
    check("async_rst_data", {16'd0, data}, 32'd0);
    check("async_rst_pulse", {31'd0, page_pulse}, 32'd0);
    @(negedge in_clk);
    btn_next = 1'b0;
    repeat (2) @(negedge in_clk);
    reset = 1'b0;
    repeat (20) @(negedge in_clk);
    check("mid_db_rst_page", {30'd0, page}, 32'd0);
    check("mid_db_rst_data", {16'd0, data}, 32'h0000FFFF);

    // Button held through reset release counts as one press.
    btn_next = 1'b1;
    reset    = 1'b1;
    repeat (3) @(negedge in_clk);
    reset = 1'b0;
    c = cyc;
    begin
      exp_t e;
      e.page   = 2'd1;
      e.data   = 16'hFFFF;
      e.at_cyc = c + DB + 2;
      sb.push_back(e);
    end
    repeat (16) @(negedge in_clk);
    check("held_rst_page", {30'd0, page}, 32'd1);
    btn_next = 1'b0;
    repeat (16) @(negedge in_clk);

    check("pending_expect", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
